voice_alloc: RTL and testbench

- Polyphonic voice allocator between the MIDI decoder (note, noteOn/noteOff strobes) and the oscillator stack.
- Replaces the plain active-voice counter with per-voice note assignment, so each oscillator plays its own note.
- Sequential scan FSM, one voice per cycle; tracks voice age for the steal policy.
- Outputs a per-voice note register and enable bit that drive each osc instance directly.

---
 rtl/voice_alloc_pkg.sv | 6 +
 rtl/voice_alloc_slot.sv | 40 ++++
 rtl/voice_alloc.sv | 146 ++++++++++++++
 tb/tb_voice_alloc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/voice_alloc_pkg.sv
// voice_alloc_pkg: shared widths and FSM/op encodings for the voice allocator
package voice_alloc_pkg;
    localparam int VOICE_AGE_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2} state_t;
    typedef enum logic {OP_ON = 1'b0, OP_OFF = 1'b1} op_t;
endpackage

// File: rtl/voice_alloc_slot.sv
// voice_slot: one voice holding note, enable and saturating age
module voice_slot
    import voice_alloc_pkg::*;
#(
    parameter int NOTE_W = 8,
    parameter int AGE_W  = VOICE_AGE_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_inc,
    input  logic [NOTE_W-1:0] i_note,
    output logic [NOTE_W-1:0] o_note,
    output logic              o_en,
    output logic [AGE_W-1:0]  o_age
);
    logic [NOTE_W-1:0] r_note;
    logic              r_en;
    logic [AGE_W-1:0]  r_age;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_note <= '0;
            r_en   <= 1'b0;
            r_age  <= '0;
        end else if (i_load) begin
            r_note <= i_note;
            r_en   <= 1'b1;
            r_age  <= '0;
        end else begin
            if (i_clear) r_en <= 1'b0;
            if (i_inc && r_en && r_age != '1) r_age <= r_age + 1'b1;
        end
    end

    assign o_note = r_note;
    assign o_en   = r_en;
    assign o_age  = r_age;
endmodule

// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator, scan FSM; VOICE_ALLOC_STEAL_EN enables oldest-voice stealing
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int VOICES = 8,
    parameter int NOTE_W = 8,
    parameter int AGE_W  = VOICE_AGE_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NOTE_W-1:0]        note_i,
    input  logic                     noteOnStrb_i,
    input  logic                     noteOffStrb_i,
    output logic [VOICES*NOTE_W-1:0] voiceNote_o,
    output logic [VOICES-1:0]        voiceEn_o,
    output logic [4:0]               activeCount_o,
    output logic                     busy_o,
    output logic                     drop_o
);
    localparam int IW = $clog2(VOICES);
`ifdef VOICE_ALLOC_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    state_t            r_state, w_state_nxt;
    op_t               r_op;
    logic [NOTE_W-1:0] r_note;
    logic [IW-1:0]     r_idx, r_match_idx, r_free_idx, r_old_idx, w_tgt;
    logic              r_match_vld, r_free_vld, r_drop;
    logic [AGE_W-1:0]  r_old_age;
    logic [4:0]        r_count, w_count;
    logic [VOICES-1:0] r_off_mask, w_en, w_load, w_clear, w_inc, w_en_nxt;
    logic [NOTE_W-1:0] w_note [VOICES];
    logic [AGE_W-1:0]  w_age [VOICES];
    logic              w_strb, w_commit, w_on_full, w_on_ok, w_drop;
    logic              w_cur_en, w_cur_eq;

    assign w_strb    = noteOnStrb_i | noteOffStrb_i;
    assign w_commit  = r_state == COMMIT;
    assign w_on_full = !r_match_vld && !r_free_vld;
    assign w_on_ok   = w_commit && r_op == OP_ON && (!w_on_full || STEAL);
    assign w_tgt     = r_match_vld ? r_match_idx : r_free_vld ? r_free_idx : r_old_idx;
    assign w_cur_en  = w_en[r_idx];
    assign w_cur_eq  = w_note[r_idx] == r_note;
    // A busy strobe, an OFF colliding with an ON, or a full ON without stealing is lost
    assign w_drop    = (r_state == IDLE) ? (noteOnStrb_i & noteOffStrb_i)
                     : (w_strb | (w_commit && r_op == OP_ON && w_on_full && !STEAL));

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = w_strb ? SCAN : IDLE;
            SCAN:    w_state_nxt = (r_idx == IW'(VOICES - 1)) ? COMMIT : SCAN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_load   = '0;
        w_inc    = '0;
        w_clear  = '0;
        w_en_nxt = '0;
        w_count  = '0;
        for (int v = 0; v < VOICES; v++) begin
            w_load[v]   = w_on_ok && w_tgt == IW'(v);
            w_inc[v]    = w_on_ok && w_tgt != IW'(v);
            w_clear[v]  = w_commit && r_op == OP_OFF && r_off_mask[v];
            w_en_nxt[v] = (w_en[v] | w_load[v]) & ~w_clear[v];
            w_count     = w_count + 5'(w_en_nxt[v]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op        <= OP_ON;
            r_note      <= '0;
            r_idx       <= '0;
            r_match_vld <= 1'b0;
            r_match_idx <= '0;
            r_free_vld  <= 1'b0;
            r_free_idx  <= '0;
            r_old_idx   <= '0;
            r_old_age   <= '0;
            r_off_mask  <= '0;
            r_count     <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (w_commit) r_count <= w_count;
            if (r_state == IDLE && w_strb) begin
                r_note      <= note_i;
                r_op        <= noteOnStrb_i ? OP_ON : OP_OFF;
                r_idx       <= '0;
                r_match_vld <= 1'b0;
                r_free_vld  <= 1'b0;
                r_old_idx   <= '0;
                r_old_age   <= '0;
                r_off_mask  <= '0;
            end
            if (r_state == SCAN) begin
                r_idx <= r_idx + 1'b1;
                if (w_cur_en && w_cur_eq) r_off_mask[r_idx] <= 1'b1;
                if (w_cur_en && w_cur_eq && !r_match_vld) begin
                    r_match_vld <= 1'b1;
                    r_match_idx <= r_idx;
                end
                if (!w_cur_en && !r_free_vld) begin
                    r_free_vld <= 1'b1;
                    r_free_idx <= r_idx;
                end
                // Strict compare keeps the lowest index on equal ages
                if (w_cur_en && w_age[r_idx] > r_old_age) begin
                    r_old_age <= w_age[r_idx];
                    r_old_idx <= r_idx;
                end
            end
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_slot
        voice_slot #(.NOTE_W(NOTE_W), .AGE_W(AGE_W)) u_slot (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_load  (w_load[v]),
            .i_clear (w_clear[v]),
            .i_inc   (w_inc[v]),
            .i_note  (r_note),
            .o_note  (w_note[v]),
            .o_en    (w_en[v]),
            .o_age   (w_age[v])
        );
        assign voiceNote_o[v*NOTE_W +: NOTE_W] = w_note[v];
    end

    assign voiceEn_o     = w_en;
    assign activeCount_o = r_count;
    assign busy_o        = r_state != IDLE;
    assign drop_o        = r_drop;
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: scoreboard bench for voice_alloc against an array-based voice model
module tb_voice_alloc;
    localparam int V = 8;
`ifdef VOICE_ALLOC_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, on = 1'b0, off = 1'b0;
    logic [7:0]  note = '0;
    logic [63:0] vnote;
    logic [7:0]  ven;
    logic [4:0]  cnt;
    logic        busy, drop;

    voice_alloc dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .note_i        (note),
        .noteOnStrb_i  (on),
        .noteOffStrb_i (off),
        .voiceNote_o   (vnote),
        .voiceEn_o     (ven),
        .activeCount_o (cnt),
        .busy_o        (busy),
        .drop_o        (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  en;
        logic [63:0] notes;
        logic [4:0]  cnt;
        logic        drop;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk = 0, n_fail = 0, drop_seen = 0, exp_drops = 0;
    int   m_note[V], m_age[V];
    bit   m_en[V];
    logic prev_busy = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t snap(logic d);
        exp_t e;
        e.en = '0; e.notes = '0; e.cnt = '0; e.drop = d;
        for (int v = 0; v < V; v++) begin
            e.en[v] = m_en[v];
            e.notes[v*8 +: 8] = 8'(m_note[v]);
            e.cnt += 5'(m_en[v]);
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < V; v++) begin
            m_note[v] = 0; m_age[v] = 0; m_en[v] = 0;
        end
    endtask

    task automatic model_on(int n);
        int t = -1;
        int best = -1;
        for (int v = 0; v < V; v++) if (t < 0 && m_en[v] && m_note[v] == n) t = v;
        for (int v = 0; v < V; v++) if (t < 0 && !m_en[v]) t = v;
        if (t < 0 && STEAL)
            for (int v = 0; v < V; v++) if (m_en[v] && m_age[v] > best) begin best = m_age[v]; t = v; end
        if (t < 0) begin
            exp_drops++;
            q.push_back(snap(1'b1));
        end else begin
            for (int v = 0; v < V; v++) if (v != t && m_en[v] && m_age[v] < 15) m_age[v]++;
            m_note[t] = n; m_en[t] = 1; m_age[t] = 0;
            q.push_back(snap(1'b0));
        end
    endtask

    task automatic model_off(int n);
        for (int v = 0; v < V; v++) if (m_en[v] && m_note[v] == n) m_en[v] = 0;
        q.push_back(snap(1'b0));
    endtask

    task automatic issue(bit o, bit f, int n);
        @(negedge clk);
        on = o; off = f; note = 8'(n);
        if (o) begin
            if (f) exp_drops++;
            model_on(n);
        end else if (f) model_off(n);
        @(negedge clk);
        on = 0; off = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 40) begin @(negedge clk); t++; end
        if (busy) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, t);
        end
        @(negedge clk);
    endtask

    task automatic on_wait(int n);
        issue(1, 0, n);
        wait_idle();
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1;
        @(negedge clk); @(negedge clk); rst = 0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (rst) prev_busy <= 1'b0;
        else begin
            if (drop) drop_seen++;
            if (prev_busy && !busy) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_commit: en=%0h with empty scoreboard", ven);
                end else begin
                    mon_e = q.pop_front();
                    chk("commit_en", ven, mon_e.en);
                    chk("commit_notes", vnote, mon_e.notes);
                    chk("commit_cnt", cnt, mon_e.cnt);
                    chk("commit_drop", drop, mon_e.drop);
                end
            end
            prev_busy <= busy;
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_en", ven, 0); chk("rst_notes", vnote, 0); chk("rst_cnt", cnt, 0);
        chk("rst_busy", busy, 0); chk("rst_drop", drop, 0);
        rst = 0;

        @(negedge clk);
        on = 1; note = 60; model_on(60);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            on = 0;
            chk("lat_en", ven, (k == 10) ? 1 : 0);
            chk("lat_busy", busy, (k < 10) ? 1 : 0);
        end
        wait_idle();
        chk("on60_note0", vnote[7:0], 60);

        do_reset();
        on_wait(60); on_wait(64); on_wait(67);
        issue(0, 1, 64); wait_idle();
        chk("off_en", ven, 8'h05); chk("off_note1", vnote[15:8], 64); chk("off_cnt", cnt, 2);
        issue(0, 1, 99); wait_idle();
        chk("off_nomatch_en", ven, 8'h05);

        do_reset();
        on_wait(60); on_wait(62); on_wait(60);
        chk("retrig_en", ven, 8'h03);
        chk("retrig_age0", dut.g_slot[0].u_slot.r_age, m_age[0]);
        chk("retrig_age1", dut.g_slot[1].u_slot.r_age, m_age[1]);

        do_reset();
        for (int n = 60; n < 68; n++) on_wait(n);
        on_wait(72);
        chk("full_en", ven, 8'hFF);
        chk("full_note0", vnote[7:0], STEAL ? 72 : 60);
        chk("full_drops", drop_seen, exp_drops);

        do_reset();
        @(negedge clk); on = 1; note = 60; model_on(60);
        @(negedge clk); on = 0;
        @(negedge clk); on = 1; note = 62; exp_drops++;
        @(negedge clk); on = 0;
        wait_idle();
        chk("busy_drops", drop_seen, exp_drops); chk("busy_en", ven, 8'h01);
        issue(1, 1, 50); wait_idle();
        chk("both_drops", drop_seen, exp_drops); chk("both_en", ven, 8'h03);

        do_reset();
        @(negedge clk); on = 1; note = 70;
        @(negedge clk); on = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_en", ven, 0); chk("mid_rst_notes", vnote, 0); chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_drop", drop, 0);
        rst = 0; model_reset();
        repeat (12) @(negedge clk);
        chk("mid_rst_nocommit", ven, 0);

        do_reset();
        repeat (150) begin
            int r, n;
            r = $urandom_range(0, 99);
            n = $urandom_range(60, 71);
            if (r < 5) issue(1, 1, n);
            else if (r < 70) issue(1, 0, n);
            else issue(0, 1, n);
            wait_idle();
        end
        chk("rand_drops", drop_seen, exp_drops);
        chk("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
